// File: rtl/io_port_pkg.sv
// io_port_pkg: register offsets and STATUS/CTRL bit positions shared by the
// io_port register window and anything that decodes it.
package io_port_pkg;

  // Register offsets within the 4-word window
  localparam logic [1:0] OFS_DATA_IN  = 2'd0;
  localparam logic [1:0] OFS_DATA_OUT = 2'd1;
  localparam logic [1:0] OFS_STATUS   = 2'd2;
  localparam logic [1:0] OFS_CTRL     = 2'd3;

  // STATUS bit positions
  localparam int ST_IN_NOT_EMPTY = 0;
  localparam int ST_OUT_NOT_FULL = 1;
  localparam int ST_IN_FULL      = 2;
  localparam int ST_OUT_EMPTY    = 3;
  localparam int ST_OVF          = 4;
  localparam int ST_UNF          = 5;

  // CTRL bit positions
  localparam int CT_CLEAR = 0;
  localparam int CT_FLUSH = 1;

endpackage

// File: rtl/io_port_fifo.sv
// sync_fifo: single-clock FIFO, 2**AW entries of W bits.
//  clk/rst  : clock, synchronous active-low reset
//  flush    : empties the FIFO; any push/pop in the same cycle is discarded
//  push     : write wdata (ignored when full)
//  pop      : advance head (ignored when empty)
//  rdata    : head word, 0 while empty
//  full     : all entries occupied
//  empty    : no entries
module sync_fifo #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2**AW];
  // One extra pointer bit tells full from empty when the index bits match.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  // Gate the head so stale storage never leaks out after reset or flush.
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_port.sv
// io_port: memory-mapped I/O responder on the control-unit data bus.
//  Window at IO_BASE..IO_BASE+3: DATA_IN (R, pops input FIFO), DATA_OUT (W,
//  pushes output FIFO), STATUS (R), CTRL (W: b0 clear flags, b1 flush FIFOs).
//  clk/rst            : clock, synchronous active-low reset
//  bus_addr/we/re     : bus access, one-cycle strobes
//  bus_wdata/bus_rdata: write data / registered read data (latency 1)
//  bus_hit            : combinational window decode for the top-level mux
//  in_data/valid/ready: external input stream into the input FIFO
//  out_data/valid/ready: output FIFO head toward the external sink
module io_port
  import io_port_pkg::*;
#(
  parameter int                  RAM_SIZE = 16,
  parameter int                  FIFO_AW  = 2,
  parameter logic [RAM_SIZE-1:0] IO_BASE  = 'hFFF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RAM_SIZE-1:0] bus_addr,
  input  logic                bus_we,
  input  logic                bus_re,
  input  logic [15:0]         bus_wdata,
  output logic [15:0]         bus_rdata,
  output logic                bus_hit,
  input  logic [15:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [15:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [1:0]  ofs;
  logic        wr, rd;
  logic        flush, clr, ovf, unf, ovf_set, unf_set;
  logic        in_full, in_empty, out_full, out_empty;
  logic        in_pop, out_push;
  logic [15:0] in_head, status, rd_val;

  assign bus_hit = (bus_addr[RAM_SIZE-1:2] == IO_BASE[RAM_SIZE-1:2]);
  assign ofs     = bus_addr[1:0];
  assign wr      = bus_we && bus_hit;
  // A write in the same cycle takes the bus; the read strobe is ignored.
  assign rd      = bus_re && bus_hit && !bus_we;

  assign flush    = wr && (ofs == OFS_CTRL) && bus_wdata[CT_FLUSH];
  assign clr      = wr && (ofs == OFS_CTRL) && bus_wdata[CT_CLEAR];
  assign in_pop   = rd && (ofs == OFS_DATA_IN) && !in_empty;
  assign unf_set  = rd && (ofs == OFS_DATA_IN) && in_empty;
  // Fullness is judged at cycle start: a same-cycle drain does not save the word.
  assign out_push = wr && (ofs == OFS_DATA_OUT) && !out_full;
  assign ovf_set  = wr && (ofs == OFS_DATA_OUT) && out_full;

  assign in_ready  = !in_full;
  assign out_valid = !out_empty;

  sync_fifo #(.W(16), .AW(FIFO_AW)) u_in_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(in_valid && !in_full), .wdata(in_data),
    .pop(in_pop), .rdata(in_head),
    .full(in_full), .empty(in_empty)
  );

  sync_fifo #(.W(16), .AW(FIFO_AW)) u_out_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(out_push), .wdata(bus_wdata),
    .pop(out_valid && out_ready), .rdata(out_data),
    .full(out_full), .empty(out_empty)
  );

  always_comb begin
    status                  = '0;
    status[ST_IN_NOT_EMPTY] = !in_empty;
    status[ST_OUT_NOT_FULL] = !out_full;
    status[ST_IN_FULL]      = in_full;
    status[ST_OUT_EMPTY]    = out_empty;
    status[ST_OVF]          = ovf;
    status[ST_UNF]          = unf;
  end

  // in_head is already 0 when the input FIFO is empty.
  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_DATA_IN: rd_val = in_head;
      OFS_STATUS:  rd_val = status;
      default:     rd_val = '0;
    endcase
  end

  // Sticky flags: a new event in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)    bus_rdata <= '0;
    else if (rd) bus_rdata <= rd_val;
  end

endmodule

// File: tb/tb_io_port.sv
module tb_io_port;

  localparam logic [15:0] A_DIN  = 16'hFFF0;
  localparam logic [15:0] A_DOUT = 16'hFFF1;
  localparam logic [15:0] A_STAT = 16'hFFF2;
  localparam logic [15:0] A_CTRL = 16'hFFF3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr, bus_wdata, bus_rdata, in_data, out_data;
  logic        bus_we, bus_re, bus_hit, in_valid, in_ready, out_valid, out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_port #(.RAM_SIZE(16), .FIFO_AW(2), .IO_BASE(16'hFFF0)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Inputs change on the falling edge; results are sampled on the next falling edge.
  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic in_push(input logic [15:0] d);
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] r;
    bus_addr = 16'h0010; bus_we = 0; bus_re = 0; bus_wdata = 0;
    in_data = 0; in_valid = 0; out_ready = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (bus_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0000", bus_rdata); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL rst_out_data got %h want 0000", out_data); end
    n_cmp++; if (bus_hit !== 1'b0) begin n_bad++; $display("FAIL hit_miss got %b want 0", bus_hit); end
    bus_addr = A_CTRL; #1;
    n_cmp++; if (bus_hit !== 1'b1) begin n_bad++; $display("FAIL hit_ctrl got %b want 1", bus_hit); end
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h000A) begin n_bad++; $display("FAIL rst_status got %h want 000A", r); end
  endtask

  task automatic test_input();
    logic [15:0] r;
    in_push(16'h1234);
    in_push(16'h5678);
    bus_read(A_DIN, r);
    n_cmp++; if (r !== 16'h1234) begin n_bad++; $display("FAIL din_first got %h want 1234", r); end
    bus_read(A_DIN, r);
    n_cmp++; if (r !== 16'h5678) begin n_bad++; $display("FAIL din_second got %h want 5678", r); end
    // Read outside the window leaves the register alone.
    bus_read(16'h0123, r);
    n_cmp++; if (r !== 16'h5678) begin n_bad++; $display("FAIL miss_hold got %h want 5678", r); end
  endtask

  task automatic test_output_fill();
    logic [15:0] r;
    out_ready = 1'b0;
    // First write also raises bus_re: the read must be ignored.
    @(negedge clk);
    bus_addr = A_DOUT; bus_wdata = 16'd1; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    n_cmp++; if (bus_rdata !== 16'h5678) begin n_bad++; $display("FAIL we_re_hold got %h want 5678", bus_rdata); end
    for (int i = 2; i <= 5; i++) bus_write(A_DOUT, 16'(i));
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h0010) begin n_bad++; $display("FAIL fill_status got %h want 0010", r); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        n_bad++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 16'(i));
      end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_underflow_clear();
    logic [15:0] r;
    bus_read(A_DIN, r);
    n_cmp++; if (r !== 16'h0) begin n_bad++; $display("FAIL unf_data got %h want 0000", r); end
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h003A) begin n_bad++; $display("FAIL unf_status got %h want 003A", r); end
    bus_write(A_CTRL, 16'h0001);
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h000A) begin n_bad++; $display("FAIL clr_status got %h want 000A", r); end
  endtask

  task automatic test_flush();
    logic [15:0] r;
    for (int i = 0; i < 3; i++) in_push(16'hA000 + 16'(i));
    for (int i = 0; i < 3; i++) bus_write(A_DOUT, 16'hB000 + 16'(i));
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h0003) begin n_bad++; $display("FAIL pre_flush got %h want 0003", r); end
    // Same-cycle input push and output pop must be discarded by the flush.
    @(negedge clk);
    bus_addr = A_CTRL; bus_wdata = 16'h0002; bus_we = 1'b1;
    in_data = 16'hDEAD; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_hs got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h000A) begin n_bad++; $display("FAIL flush_status got %h want 000A", r); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    in_push(16'h0100);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      in_data = 16'h0100 + 16'(i); in_valid = 1'b1;
      bus_addr = A_DIN; bus_re = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; bus_re = 1'b0;
      n_cmp++; if (bus_rdata !== 16'h0100 + 16'(i - 1)) begin
        n_bad++; $display("FAIL stream_%0d got %h want %h", i, bus_rdata, 16'h0100 + 16'(i - 1));
      end
    end
    bus_read(A_DIN, r);
    n_cmp++; if (r !== 16'h0113) begin n_bad++; $display("FAIL stream_last got %h want 0113", r); end
    bus_read(A_STAT, r);
    n_cmp++; if (r !== 16'h000A) begin n_bad++; $display("FAIL stream_status got %h want 000A", r); end
  endtask

  task automatic test_reset_mid();
    in_push(16'h7777);
    bus_write(A_DOUT, 16'h8888);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0) begin
      n_bad++; $display("FAIL mid_reset got rdy=%b ov=%b od=%h want 1 0 0000", in_ready, out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_input();
    test_output_fill();
    test_underflow_clear();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
